uart_tx_engine: RTL and testbench

- Transmit serializer directly downstream of the protocol config/FIFO block.
- When enabled, pops bytes from the TX FIFO and shifts each out on uart_txd as a UART frame: start bit, 8 data bits LSB first, optional parity, 1 or 2 stop bits. Bit timing comes from the baud compare value.
- When the FIFO drains, pulses tx_rst back to the config block, which clears tx_en.

---
 rtl/uart_tx_engine.sv | 242 ++++++++++++++++++++++++
 tb/tb_uart_tx_engine.sv | 393 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_engine.sv
// ----------------------------------------------------------------------------
// uart_tx_engine
//
// Purpose:
//   Transmit serializer that sits directly downstream of the protocol
//   config/FIFO block. While tx_en is high it pops bytes from the TX FIFO and
//   shifts each one out on uart_txd as a UART frame:
//     start bit, DATA_W data bits LSB first, optional parity bit, and 1 or 2
//     stop bits.
//   Each bit lasts (baud_cmpval + 1) glb_clk cycles. When the FIFO runs dry
//   with tx_en still high, the engine pulses tx_rst for one cycle. The config
//   block clears tx_en on that pulse.
//
// Configuration macro:
//   UART_TX_ODD_PARITY_EN - when defined, the parity bit is odd parity.
//                           When undefined (the default), it is even parity.
//
// Ports:
//   glb_clk      in   system clock
//   glb_rstn     in   asynchronous active-low reset
//   tx_en        in   transmit enable from the config block
//   baud_cmpval  in   bit period minus one, in glb_clk cycles
//   parity_cfg   in   1 = insert a parity bit
//   stop_cfg     in   0 = one stop bit, 1 = two stop bits
//   fifo_rdata   in   TX FIFO head word (first-word-fall-through)
//   fifo_empty   in   TX FIFO empty flag
//   fifo_r_en    out  one-cycle pop strobe (decoded from the FSM)
//   tx_rst       out  one-cycle "queue drained" pulse (registered)
//   uart_txd     out  serial line, idles high (registered)
//   tx_busy      out  high while a frame is on the line (registered)
//
// Handshake: fifo_r_en is a pop strobe against the FIFO's !fifo_empty
// "valid". The pop is accepted on the clock edge that ends a cycle in which
// fifo_r_en = 1. fifo_r_en is only raised when fifo_empty = 0. The head word
// is captured on that same edge.
// ----------------------------------------------------------------------------
module uart_tx_engine #(
    parameter int DATA_W = 8,
    parameter int CNT_W  = 8
) (
    input  logic              glb_clk,
    input  logic              glb_rstn,
    input  logic              tx_en,
    input  logic [CNT_W-1:0]  baud_cmpval,
    input  logic              parity_cfg,
    input  logic              stop_cfg,
    input  logic [DATA_W-1:0] fifo_rdata,
    input  logic              fifo_empty,
    output logic              fifo_r_en,
    output logic              tx_rst,
    output logic              uart_txd,
    output logic              tx_busy
);

    localparam int BIT_W = $clog2(DATA_W + 1);
    localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(DATA_W - 1);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4,
        ST_FLUSH  = 3'd5
    } state_t;

    state_t             state_q,    state_d;
    logic [CNT_W-1:0]   baud_cnt_q, baud_cnt_d;
    logic [BIT_W-1:0]   bit_cnt_q,  bit_cnt_d;
    logic [DATA_W-1:0]  shift_q,    shift_d;
    logic [CNT_W-1:0]   cmp_q,      cmp_d;
    logic               par_en_q,   par_en_d;
    logic               stop2_q,    stop2_d;
    logic               par_bit_q,  par_bit_d;
    logic               txd_q,      txd_d;
    logic               busy_q,     busy_d;
    logic               rst_q,      rst_d;

    logic               bit_end;
    logic               can_load;
    logic               data_par;

    assign bit_end  = (baud_cnt_q == cmp_q);
    assign can_load = tx_en && !fifo_empty;

`ifdef UART_TX_ODD_PARITY_EN
    assign data_par = ~(^fifo_rdata);
`else
    assign data_par = ^fifo_rdata;
`endif

    // Next-state and datapath logic
    always_comb begin
        state_d    = state_q;
        baud_cnt_d = baud_cnt_q;
        bit_cnt_d  = bit_cnt_q;
        shift_d    = shift_q;
        cmp_d      = cmp_q;
        par_en_d   = par_en_q;
        stop2_d    = stop2_q;
        par_bit_d  = par_bit_q;
        fifo_r_en  = 1'b0;

        // Frame loading is shared by IDLE and the last STOP cycle. Latching the
        // config here keeps it constant for the whole frame.
        unique case (state_q)
            ST_IDLE: begin
                baud_cnt_d = '0;
                bit_cnt_d  = '0;
                if (can_load) begin
                    fifo_r_en = 1'b1;
                    shift_d   = fifo_rdata;
                    cmp_d     = baud_cmpval;
                    par_en_d  = parity_cfg;
                    stop2_d   = stop_cfg;
                    par_bit_d = data_par;
                    state_d   = ST_START;
                end else if (tx_en) begin
                    state_d = ST_FLUSH;
                end
            end

            ST_START: begin
                if (bit_end) begin
                    baud_cnt_d = '0;
                    state_d    = ST_DATA;
                end else begin
                    baud_cnt_d = baud_cnt_q + CNT_W'(1);
                end
            end

            ST_DATA: begin
                if (bit_end) begin
                    baud_cnt_d = '0;
                    shift_d    = shift_q >> 1;
                    if (bit_cnt_q == LAST_BIT) begin
                        bit_cnt_d = '0;
                        state_d   = par_en_q ? ST_PARITY : ST_STOP;
                    end else begin
                        bit_cnt_d = bit_cnt_q + BIT_W'(1);
                    end
                end else begin
                    baud_cnt_d = baud_cnt_q + CNT_W'(1);
                end
            end

            ST_PARITY: begin
                if (bit_end) begin
                    baud_cnt_d = '0;
                    state_d    = ST_STOP;
                end else begin
                    baud_cnt_d = baud_cnt_q + CNT_W'(1);
                end
            end

            ST_STOP: begin
                if (bit_end) begin
                    baud_cnt_d = '0;
                    // In STOP, bit_cnt counts the stop bits already sent.
                    if (stop2_q && (bit_cnt_q == '0)) begin
                        bit_cnt_d = BIT_W'(1);
                    end else begin
                        bit_cnt_d = '0;
                        if (can_load) begin
                            // Back-to-back: the next start bit follows with no gap.
                            fifo_r_en = 1'b1;
                            shift_d   = fifo_rdata;
                            cmp_d     = baud_cmpval;
                            par_en_d  = parity_cfg;
                            stop2_d   = stop_cfg;
                            par_bit_d = data_par;
                            state_d   = ST_START;
                        end else if (tx_en) begin
                            state_d = ST_FLUSH;
                        end else begin
                            state_d = ST_IDLE;
                        end
                    end
                end else begin
                    baud_cnt_d = baud_cnt_q + CNT_W'(1);
                end
            end

            ST_FLUSH: begin
                state_d = ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Registered outputs are decoded from the next state, so they line up
    // cycle-for-cycle with state_q.
    always_comb begin
        txd_d  = 1'b1;
        busy_d = 1'b0;
        rst_d  = 1'b0;
        unique case (state_d)
            ST_START:  begin txd_d = 1'b0;       busy_d = 1'b1; end
            ST_DATA:   begin txd_d = shift_d[0]; busy_d = 1'b1; end
            ST_PARITY: begin txd_d = par_bit_d;  busy_d = 1'b1; end
            ST_STOP:   begin txd_d = 1'b1;       busy_d = 1'b1; end
            ST_FLUSH:  begin rst_d = 1'b1; end
            default:   begin txd_d = 1'b1; end
        endcase
    end

    always_ff @(posedge glb_clk or negedge glb_rstn) begin
        if (!glb_rstn) begin
            state_q    <= ST_IDLE;
            baud_cnt_q <= '0;
            bit_cnt_q  <= '0;
            shift_q    <= '0;
            cmp_q      <= '0;
            par_en_q   <= 1'b0;
            stop2_q    <= 1'b0;
            par_bit_q  <= 1'b0;
            txd_q      <= 1'b1;
            busy_q     <= 1'b0;
            rst_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            baud_cnt_q <= baud_cnt_d;
            bit_cnt_q  <= bit_cnt_d;
            shift_q    <= shift_d;
            cmp_q      <= cmp_d;
            par_en_q   <= par_en_d;
            stop2_q    <= stop2_d;
            par_bit_q  <= par_bit_d;
            txd_q      <= txd_d;
            busy_q     <= busy_d;
            rst_q      <= rst_d;
        end
    end

    assign uart_txd = txd_q;
    assign tx_busy  = busy_q;
    assign tx_rst   = rst_q;

endmodule

// File: tb/tb_uart_tx_engine.sv
// ----------------------------------------------------------------------------
// tb_uart_tx_engine
// Directed testbench for uart_tx_engine. A queue models the FIFO. The config
// block is modelled by clearing tx_en on the tx_rst edge. Each clock cycle's
// outputs are logged at the falling edge, and the tests compare those logs
// against hand-built expected line waveforms held in exp_q.
// ----------------------------------------------------------------------------
module tb_uart_tx_engine;

  localparam int DATA_W = 8;
  localparam int CNT_W  = 8;

  localparam int F_TXD  = 0;
  localparam int F_BUSY = 1;
  localparam int F_RST  = 2;
  localparam int F_POP  = 3;

`ifdef UART_TX_ODD_PARITY_EN
  localparam logic PAR_A5 = 1'b1;
`else
  localparam logic PAR_A5 = 1'b0;
`endif

  // ---------------- clock / reset / DUT ----------------
  logic              glb_clk = 1'b0;
  logic              glb_rstn;
  logic              tx_en;
  logic [CNT_W-1:0]  baud_cmpval;
  logic              parity_cfg;
  logic              stop_cfg;
  logic [DATA_W-1:0] fifo_rdata;
  logic              fifo_empty;
  logic              fifo_r_en;
  logic              tx_rst;
  logic              uart_txd;
  logic              tx_busy;

  always #5 glb_clk = ~glb_clk;

  uart_tx_engine #(.DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
    .glb_clk     (glb_clk),
    .glb_rstn    (glb_rstn),
    .tx_en       (tx_en),
    .baud_cmpval (baud_cmpval),
    .parity_cfg  (parity_cfg),
    .stop_cfg    (stop_cfg),
    .fifo_rdata  (fifo_rdata),
    .fifo_empty  (fifo_empty),
    .fifo_r_en   (fifo_r_en),
    .tx_rst      (tx_rst),
    .uart_txd    (uart_txd),
    .tx_busy     (tx_busy)
  );

  // ---------------- bench state ----------------
  typedef struct packed {
    logic txd;
    logic busy;
    logic rst;
    logic pop;
  } samp_t;

  logic [DATA_W-1:0] fq[$];
  samp_t             log_q[$];
  logic [0:0]        exp_q[$];
  int                tests_run    = 0;
  int                tests_failed = 0;
  int                bad_pop      = 0;

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation time limit reached");
    $fatal(1, "timeout");
  end

  // ---------------- driver tasks ----------------
  task automatic upd_fifo();
    fifo_empty = (fq.size() == 0);
    fifo_rdata = (fq.size() != 0) ? fq[0] : '0;
  endtask

  task automatic clear_log();
    log_q.delete();
    exp_q.delete();
  endtask

  // One clock: log outputs mid-cycle, then apply the FIFO pop and the
  // config block's tx_en clear just after the edge.
  task automatic cycle();
    logic popped;
    logic flushed;
    samp_t s;
    @(negedge glb_clk);
    popped  = fifo_r_en;
    flushed = tx_rst;
    if (fifo_r_en && fifo_empty) bad_pop++;
    s.txd  = uart_txd;
    s.busy = tx_busy;
    s.rst  = tx_rst;
    s.pop  = fifo_r_en;
    log_q.push_back(s);
    @(posedge glb_clk);
    #1;
    if (popped && fq.size() != 0) void'(fq.pop_front());
    if (flushed) tx_en = 1'b0;
    upd_fifo();
  endtask

  // Expected line waveform for one frame, one entry per clock.
  task automatic build_frame(input logic [7:0] data, input logic par,
                             input logic stop2, input int cmp);
    logic [0:0] bits[$];
    logic       p;
    p = ^data;
`ifdef UART_TX_ODD_PARITY_EN
    p = ~p;
`endif
    bits.push_back(1'b0);
    for (int i = 0; i < 8; i++) bits.push_back(data[i]);
    if (par) bits.push_back(p);
    bits.push_back(1'b1);
    if (stop2) bits.push_back(1'b1);
    foreach (bits[i]) begin
      for (int k = 0; k <= cmp; k++) exp_q.push_back(bits[i]);
    end
  endtask

  function automatic logic get_f(input int i, input int sel);
    case (sel)
      F_TXD:   return log_q[i].txd;
      F_BUSY:  return log_q[i].busy;
      F_RST:   return log_q[i].rst;
      default: return log_q[i].pop;
    endcase
  endfunction

  function automatic int find_idx(input int sel, input int from);
    for (int i = from; i < log_q.size(); i++) if (get_f(i, sel)) return i;
    return -1;
  endfunction

  function automatic int count_f(input int sel);
    int n = 0;
    for (int i = 0; i < log_q.size(); i++) if (get_f(i, sel)) n++;
    return n;
  endfunction

  // Count of cycles from 'start' whose uart_txd differs from exp_q.
  function automatic int frame_mism(input int start);
    int n = 0;
    if (start < 0) return exp_q.size();
    for (int i = 0; i < exp_q.size(); i++) begin
      if (start + i >= log_q.size()) n++;
      else if (log_q[start + i].txd !== exp_q[i][0]) n++;
    end
    return n;
  endfunction

  // ---------------- tests ----------------
  task automatic test_reset();
    glb_rstn    = 1'b0;
    tx_en       = 1'b0;
    baud_cmpval = '0;
    parity_cfg  = 1'b0;
    stop_cfg    = 1'b0;
    upd_fifo();
    repeat (3) @(posedge glb_clk);
    #1;
    tests_run++;
    if ({uart_txd, tx_busy, tx_rst, fifo_r_en} !== 4'b1000) begin
      tests_failed++;
      $display("FAIL reset_outputs: got txd/busy/rst/ren=%b, want 1000",
               {uart_txd, tx_busy, tx_rst, fifo_r_en});
    end
    @(negedge glb_clk);
    glb_rstn = 1'b1;
    repeat (3) cycle();
    tests_run++;
    if (count_f(F_TXD) !== 3 || count_f(F_BUSY) !== 0 || count_f(F_RST) !== 0) begin
      tests_failed++;
      $display("FAIL idle_after_reset: got txd_hi=%0d busy=%0d rst=%0d, want 3 0 0",
               count_f(F_TXD), count_f(F_BUSY), count_f(F_RST));
    end
  endtask

  task automatic test_single_frame();
    int p;
    clear_log();
    baud_cmpval = 8'd3; parity_cfg = 1'b1; stop_cfg = 1'b0;
    fq.push_back(8'hA5); upd_fifo();
    tx_en = 1'b1;
    repeat (60) cycle();
    build_frame(8'hA5, 1'b1, 1'b0, 3);
    p = find_idx(F_POP, 0);
    tests_run++;
    if (count_f(F_POP) !== 1 || p !== 0) begin
      tests_failed++;
      $display("FAIL single_pop: got count=%0d idx=%0d, want 1 at 0", count_f(F_POP), p);
    end
    tests_run++;
    if (exp_q.size() !== 44 || frame_mism(p + 1) !== 0) begin
      tests_failed++;
      $display("FAIL single_frame_a5: got %0d mismatching cycles (len %0d), want 0 (len 44)",
               frame_mism(p + 1), exp_q.size());
    end
    tests_run++;
    if (log_q[p + 1 + 36].txd !== PAR_A5) begin
      tests_failed++;
      $display("FAIL parity_a5: got %b, want %b", log_q[p + 1 + 36].txd, PAR_A5);
    end
    tests_run++;
    if (count_f(F_RST) !== 1 || find_idx(F_RST, 0) !== p + 45) begin
      tests_failed++;
      $display("FAIL single_tx_rst: got count=%0d idx=%0d, want 1 at %0d",
               count_f(F_RST), find_idx(F_RST, 0), p + 45);
    end
    tests_run++;
    if (count_f(F_BUSY) !== 44) begin
      tests_failed++;
      $display("FAIL single_busy: got %0d busy cycles, want 44", count_f(F_BUSY));
    end
  endtask

  task automatic test_back_to_back();
    int p;
    int p2;
    clear_log();
    baud_cmpval = 8'd3; parity_cfg = 1'b1; stop_cfg = 1'b0;
    fq.push_back(8'h01); fq.push_back(8'h80); upd_fifo();
    tx_en = 1'b1;
    repeat (110) cycle();
    build_frame(8'h01, 1'b1, 1'b0, 3);
    build_frame(8'h80, 1'b1, 1'b0, 3);
    p  = find_idx(F_POP, 0);
    p2 = (p < 0) ? -1 : find_idx(F_POP, p + 1);
    tests_run++;
    if (count_f(F_POP) !== 2 || p2 !== p + 44) begin
      tests_failed++;
      $display("FAIL b2b_pops: got count=%0d second_idx=%0d, want 2 at %0d",
               count_f(F_POP), p2, p + 44);
    end
    tests_run++;
    if (frame_mism(p + 1) !== 0) begin
      tests_failed++;
      $display("FAIL b2b_frames: got %0d mismatching cycles, want 0", frame_mism(p + 1));
    end
    tests_run++;
    if (count_f(F_RST) !== 1 || find_idx(F_RST, 0) !== p + 89) begin
      tests_failed++;
      $display("FAIL b2b_tx_rst: got count=%0d idx=%0d, want 1 at %0d",
               count_f(F_RST), find_idx(F_RST, 0), p + 89);
    end
  endtask

  task automatic test_fast_two_stop();
    int p;
    clear_log();
    baud_cmpval = 8'd0; parity_cfg = 1'b0; stop_cfg = 1'b1;
    fq.push_back(8'hFF); upd_fifo();
    tx_en = 1'b1;
    repeat (20) cycle();
    build_frame(8'hFF, 1'b0, 1'b1, 0);
    p = find_idx(F_POP, 0);
    tests_run++;
    if (exp_q.size() !== 11 || frame_mism(p + 1) !== 0) begin
      tests_failed++;
      $display("FAIL fast_frame_ff: got %0d mismatching cycles (len %0d), want 0 (len 11)",
               frame_mism(p + 1), exp_q.size());
    end
    tests_run++;
    if (count_f(F_BUSY) !== 11) begin
      tests_failed++;
      $display("FAIL fast_busy: got %0d busy cycles, want 11", count_f(F_BUSY));
    end
    tests_run++;
    if (find_idx(F_RST, 0) !== p + 12) begin
      tests_failed++;
      $display("FAIL fast_tx_rst: got idx=%0d, want %0d", find_idx(F_RST, 0), p + 12);
    end
  endtask

  task automatic test_en_drop();
    int p;
    int hi;
    clear_log();
    baud_cmpval = 8'd3; parity_cfg = 1'b0; stop_cfg = 1'b0;
    fq.push_back(8'h11); fq.push_back(8'h22); fq.push_back(8'h33); upd_fifo();
    tx_en = 1'b1;
    repeat (12) cycle();
    tx_en = 1'b0;
    repeat (50) cycle();
    build_frame(8'h11, 1'b0, 1'b0, 3);
    p = find_idx(F_POP, 0);
    tests_run++;
    if (count_f(F_POP) !== 1 || fq.size() !== 2) begin
      tests_failed++;
      $display("FAIL en_drop_pops: got pops=%0d left=%0d, want 1 and 2",
               count_f(F_POP), fq.size());
    end
    tests_run++;
    if (frame_mism(p + 1) !== 0) begin
      tests_failed++;
      $display("FAIL en_drop_frame: got %0d mismatching cycles, want 0", frame_mism(p + 1));
    end
    hi = 0;
    for (int i = p + 41; i < log_q.size(); i++) if (log_q[i].txd === 1'b1) hi++;
    tests_run++;
    if (count_f(F_RST) !== 0 || hi !== log_q.size() - (p + 41)) begin
      tests_failed++;
      $display("FAIL en_drop_idle: got rst=%0d high=%0d, want 0 and %0d",
               count_f(F_RST), hi, log_q.size() - (p + 41));
    end
    fq.delete(); upd_fifo();
  endtask

  task automatic test_config_latch();
    int p;
    clear_log();
    baud_cmpval = 8'd1; parity_cfg = 1'b0; stop_cfg = 1'b0;
    fq.push_back(8'h3C); upd_fifo();
    tx_en = 1'b1;
    repeat (6) cycle();
    baud_cmpval = 8'd0; parity_cfg = 1'b1; stop_cfg = 1'b1;
    repeat (30) cycle();
    build_frame(8'h3C, 1'b0, 1'b0, 1);
    p = find_idx(F_POP, 0);
    tests_run++;
    if (frame_mism(p + 1) !== 0) begin
      tests_failed++;
      $display("FAIL cfg_latch_frame: got %0d mismatching cycles, want 0", frame_mism(p + 1));
    end
    tests_run++;
    if (find_idx(F_RST, 0) !== p + 21) begin
      tests_failed++;
      $display("FAIL cfg_latch_tx_rst: got idx=%0d, want %0d", find_idx(F_RST, 0), p + 21);
    end
  endtask

  task automatic test_reset_mid_frame();
    clear_log();
    baud_cmpval = 8'd3; parity_cfg = 1'b0; stop_cfg = 1'b0;
    fq.push_back(8'h5A); upd_fifo();
    tx_en = 1'b1;
    repeat (10) cycle();
    tests_run++;
    if (log_q[9].busy !== 1'b1) begin
      tests_failed++;
      $display("FAIL mid_frame_busy: got %b, want 1", log_q[9].busy);
    end
    @(negedge glb_clk);
    glb_rstn = 1'b0;
    #1;
    tests_run++;
    if (uart_txd !== 1'b1 || tx_busy !== 1'b0 || tx_rst !== 1'b0) begin
      tests_failed++;
      $display("FAIL mid_frame_reset: got txd=%b busy=%b rst=%b, want 1 0 0",
               uart_txd, tx_busy, tx_rst);
    end
    repeat (3) @(posedge glb_clk);
    @(negedge glb_clk);
    glb_rstn = 1'b1;
    clear_log();
    repeat (8) cycle();
    tests_run++;
    if (count_f(F_RST) !== 1 || count_f(F_POP) !== 0 || count_f(F_BUSY) !== 0) begin
      tests_failed++;
      $display("FAIL post_reset_flush: got rst=%0d pops=%0d busy=%0d, want 1 0 0",
               count_f(F_RST), count_f(F_POP), count_f(F_BUSY));
    end
  endtask

  task automatic test_no_empty_pop();
    tests_run++;
    if (bad_pop !== 0) begin
      tests_failed++;
      $display("FAIL pop_when_empty: got %0d pops while empty, want 0", bad_pop);
    end
  endtask

  initial begin
    test_reset();
    test_single_frame();
    test_back_to_back();
    test_fast_two_stop();
    test_en_drop();
    test_config_latch();
    test_reset_mid_frame();
    test_no_empty_pop();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
